// File: rtl/rob_commit_buffer_pkg.sv
// Shared constants and types for the reorder/commit buffer.
//   ROB_DATA_WIDTH  : result/value width (Data_Width)
//   ROB_ENTRY_WIDTH : entry index width (ROB_Entry_Width)
//   ROB_DEPTH       : number of entries (ROB_Depth)
//   ROB_REG_WIDTH   : architectural register index width (Reg_Index_Width)
//   REG_NO_LOCK     : regfile lock encoding meaning "no producer in flight"
package rob_commit_buffer_pkg;
  localparam int ROB_DATA_WIDTH  = 32;
  localparam int ROB_ENTRY_WIDTH = 3;
  localparam int ROB_DEPTH       = 2**ROB_ENTRY_WIDTH;
  localparam int ROB_REG_WIDTH   = 5;
  localparam logic [ROB_ENTRY_WIDTH:0] REG_NO_LOCK = '1;

  // One allocation as seen by a consumer tracking program order.
  typedef struct packed {
    logic [ROB_ENTRY_WIDTH-1:0] entry;
    logic [ROB_REG_WIDTH-1:0]   dest;
  } rob_alloc_rec_t;
endpackage

// File: rtl/rob_commit_buffer_if.sv
// Bundle of all non-clock signals of the commit buffer.
//   alloc_*  : decode allocation handshake (valid/ready, granted entry)
//   cdb_*    : completion writes from the CDB
//   q1_/q2_* : operand lookups from issue
//   commit_* : in-order retire stream to the register file
//   rob_count: occupied entries
// master = decode/CDB/issue/regfile side, slave = the buffer itself.
interface rob_commit_buffer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ENTRY_WIDTH = 3,
  parameter int REG_WIDTH   = 5
);
  logic                   alloc_valid;
  logic [REG_WIDTH-1:0]   alloc_dest_reg;
  logic                   alloc_ready;
  logic [ENTRY_WIDTH-1:0] alloc_entry;
  logic                   cdb_write;
  logic [ENTRY_WIDTH-1:0] cdb_entry;
  logic [DATA_WIDTH-1:0]  cdb_value;
  logic [ENTRY_WIDTH-1:0] q1_entry, q2_entry;
  logic                   q1_ready, q2_ready;
  logic [DATA_WIDTH-1:0]  q1_value, q2_value;
  logic                   commit_valid;
  logic [ENTRY_WIDTH-1:0] commit_entry;
  logic [REG_WIDTH-1:0]   commit_reg;
  logic [DATA_WIDTH-1:0]  commit_value;
  logic [ENTRY_WIDTH:0]   rob_count;

  modport master (
    output alloc_valid, alloc_dest_reg, cdb_write, cdb_entry, cdb_value,
           q1_entry, q2_entry,
    input  alloc_ready, alloc_entry, q1_ready, q2_ready, q1_value, q2_value,
           commit_valid, commit_entry, commit_reg, commit_value, rob_count
  );
  modport slave (
    input  alloc_valid, alloc_dest_reg, cdb_write, cdb_entry, cdb_value,
           q1_entry, q2_entry,
    output alloc_ready, alloc_entry, q1_ready, q2_ready, q1_value, q2_value,
           commit_valid, commit_entry, commit_reg, commit_value, rob_count
  );
endinterface

// File: rtl/rob_commit_buffer_query_port.sv
// One combinational operand lookup port.
//   q_entry            : entry being looked up
//   cdb_write/entry/val: current-cycle CDB result, forwarded if it completes q_entry
//   busy/done/value    : registered entry state
//   q_ready/q_value    : value available / value (0 when not available)
module rob_query_port #(
  parameter int DEPTH       = 8,
  parameter int ENTRY_WIDTH = 3,
  parameter int DATA_WIDTH  = 32
) (
  input  logic [ENTRY_WIDTH-1:0]            q_entry,
  input  logic                              cdb_write,
  input  logic [ENTRY_WIDTH-1:0]            cdb_entry,
  input  logic [DATA_WIDTH-1:0]             cdb_value,
  input  logic [DEPTH-1:0]                  busy,
  input  logic [DEPTH-1:0]                  done,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0]  value,
  output logic                              q_ready,
  output logic [DATA_WIDTH-1:0]             q_value
);
  always_comb begin
    q_ready = 1'b0;
    q_value = '0;
    // Bypass only for a pending entry; a done entry keeps its first result.
    if (cdb_write && (cdb_entry == q_entry) && busy[q_entry] && !done[q_entry]) begin
      q_ready = 1'b1;
      q_value = cdb_value;
    end else if (busy[q_entry] && done[q_entry]) begin
      q_ready = 1'b1;
      q_value = value[q_entry];
    end
  end
endmodule

// File: rtl/rob_commit_buffer.sv
// Reorder buffer downstream of the CDB. Decode allocates in program order,
// the CDB completes entries, and completed results retire in order, one per
// cycle. Two lookup ports let issue read results before they commit.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : rob_commit_buffer_if.slave (alloc, cdb, q1/q2, commit, rob_count)
module rob_commit_buffer
  import rob_commit_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = ROB_DATA_WIDTH,
  parameter int ENTRY_WIDTH = ROB_ENTRY_WIDTH,
  parameter int REG_WIDTH   = ROB_REG_WIDTH
) (
  input  logic clk,
  input  logic rst,
  rob_commit_buffer_if.slave bus
);
  localparam int DEPTH     = 2**ENTRY_WIDTH;
  localparam int NUM_PORTS = 2;
  localparam logic [ENTRY_WIDTH:0] FULL_CNT = (ENTRY_WIDTH+1)'(DEPTH);

  logic [ENTRY_WIDTH-1:0]            head_q, head_d, tail_q, tail_d;
  logic [ENTRY_WIDTH:0]              count_q, count_d;
  logic [DEPTH-1:0]                  busy_q, busy_d, done_q, done_d;
  logic [DEPTH-1:0][REG_WIDTH-1:0]   dest_q, dest_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]  value_q, value_d;
  logic                              commit_valid_q, commit_valid_d;
  logic [ENTRY_WIDTH-1:0]            commit_entry_q, commit_entry_d;
  logic [REG_WIDTH-1:0]              commit_reg_q, commit_reg_d;
  logic [DATA_WIDTH-1:0]             commit_value_q, commit_value_d;
  logic                              do_alloc, do_cdb, do_commit;

  always_comb begin
    // Full check uses registered count only: a same-cycle commit never frees a slot early.
    do_alloc  = bus.alloc_valid && (count_q != FULL_CNT);
    do_cdb    = bus.cdb_write && busy_q[bus.cdb_entry] && !done_q[bus.cdb_entry];
    do_commit = busy_q[head_q] && done_q[head_q];

    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    busy_d         = busy_q;
    done_d         = done_q;
    dest_d         = dest_q;
    value_d        = value_q;
    commit_valid_d = do_commit;
    commit_entry_d = commit_entry_q;
    commit_reg_d   = commit_reg_q;
    commit_value_d = commit_value_q;

    if (do_cdb) begin
      value_d[bus.cdb_entry] = bus.cdb_value;
      done_d[bus.cdb_entry]  = 1'b1;
    end

    if (do_commit) begin
      commit_entry_d = head_q;
      commit_reg_d   = dest_q[head_q];
      commit_value_d = value_q[head_q];
      busy_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end

    // tail can only equal a busy head when full, where alloc is refused,
    // so this never collides with the commit clear above.
    if (do_alloc) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      dest_d[tail_q] = bus.alloc_dest_reg;
      tail_d         = tail_q + 1'b1;
    end

    case ({do_alloc, do_commit})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      done_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_entry_q <= '0;
      commit_reg_q   <= '0;
      commit_value_q <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      commit_valid_q <= commit_valid_d;
      commit_entry_q <= commit_entry_d;
      commit_reg_q   <= commit_reg_d;
      commit_value_q <= commit_value_d;
    end
  end

  // Payload is qualified by busy/done, so it carries no reset.
  always_ff @(posedge clk) begin
    dest_q  <= dest_d;
    value_q <= value_d;
  end

  logic [NUM_PORTS-1:0][ENTRY_WIDTH-1:0] q_entry;
  logic [NUM_PORTS-1:0]                  q_ready;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  q_value;

  assign q_entry[0] = bus.q1_entry;
  assign q_entry[1] = bus.q2_entry;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_qport
    rob_query_port #(
      .DEPTH       (DEPTH),
      .ENTRY_WIDTH (ENTRY_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH)
    ) u_qport (
      .q_entry   (q_entry[p]),
      .cdb_write (bus.cdb_write),
      .cdb_entry (bus.cdb_entry),
      .cdb_value (bus.cdb_value),
      .busy      (busy_q),
      .done      (done_q),
      .value     (value_q),
      .q_ready   (q_ready[p]),
      .q_value   (q_value[p])
    );
  end

  assign bus.q1_ready     = q_ready[0];
  assign bus.q1_value     = q_value[0];
  assign bus.q2_ready     = q_ready[1];
  assign bus.q2_value     = q_value[1];
  assign bus.alloc_ready  = (count_q != FULL_CNT);
  assign bus.alloc_entry  = tail_q;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_entry = commit_entry_q;
  assign bus.commit_reg   = commit_reg_q;
  assign bus.commit_value = commit_value_q;
  assign bus.rob_count    = count_q;
endmodule

// File: tb/tb_rob_commit_buffer.sv
module tb_rob_commit_buffer;
  import rob_commit_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rob_commit_buffer_if #(.DATA_WIDTH(32), .ENTRY_WIDTH(3), .REG_WIDTH(5)) bus ();

  rob_commit_buffer #(.DATA_WIDTH(32), .ENTRY_WIDTH(3), .REG_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  rob_alloc_rec_t sb[$];
  logic [31:0]    mdl_val [8];
  logic [2:0]     mdl_tail = '0;

  typedef struct {
    logic [2:0]  q1, q2;
    logic        cw;
    logic [2:0]  ce;
    logic [31:0] cv;
    logic        r1;
    logic [31:0] v1;
    logic        r2;
    logic [31:0] v2;
  } qvec_t;
  qvec_t qv [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [4:0] dest, input bit exp_ok);
    bus.alloc_valid    = 1'b1;
    bus.alloc_dest_reg = dest;
    #1;
    check("alloc_ready", {63'd0, bus.alloc_ready}, {63'd0, exp_ok});
    if (exp_ok) begin
      check("alloc_entry", {61'd0, bus.alloc_entry}, {61'd0, mdl_tail});
      sb.push_back('{entry: mdl_tail, dest: dest});
      mdl_tail++;
    end
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] e, input logic [31:0] v, input bit taken);
    bus.cdb_write = 1'b1;
    bus.cdb_entry = e;
    bus.cdb_value = v;
    if (taken) mdl_val[e] = v;
    tick();
    bus.cdb_write = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Commit monitor: every retire must match the oldest outstanding allocation.
  always @(negedge clk) begin
    if (rst && bus.commit_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: entry %0d value 0x%0h", bus.commit_entry, bus.commit_value);
      end else begin
        rob_alloc_rec_t r;
        r = sb.pop_front();
        check("commit_entry", {61'd0, bus.commit_entry}, {61'd0, r.entry});
        check("commit_reg",   {59'd0, bus.commit_reg},   {59'd0, r.dest});
        check("commit_value", {32'd0, bus.commit_value}, {32'd0, mdl_val[r.entry]});
      end
    end
  end

  initial begin
    bus.alloc_valid = 0; bus.alloc_dest_reg = 0;
    bus.cdb_write = 0; bus.cdb_entry = 0; bus.cdb_value = 0;
    bus.q1_entry = 0; bus.q2_entry = 0;
    for (int i = 0; i < 8; i++) mdl_val[i] = '0;

    // Reset, then idle.
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_count", 64'(bus.rob_count), 64'd0);
      check("idle_ready", 64'(bus.alloc_ready), 64'd1);
      check("idle_entry", 64'(bus.alloc_entry), 64'd0);
      check("idle_cvalid", 64'(bus.commit_valid), 64'd0);
    end

    // Out-of-order completion, in-order retire.
    alloc(5'd1, 1); alloc(5'd2, 1); alloc(5'd3, 1);
    check("count3", 64'(bus.rob_count), 64'd3);
    cdb(3'd2, 32'h33, 1);
    check("no_commit_e2", 64'(bus.commit_valid), 64'd0);
    cdb(3'd1, 32'h22, 1);
    check("no_commit_e1", 64'(bus.commit_valid), 64'd0);
    cdb(3'd0, 32'h11, 1);
    check("lat_no_bypass", 64'(bus.commit_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seq_cvalid", 64'(bus.commit_valid), 64'd1);
      check("seq_centry", 64'(bus.commit_entry), 64'(i));
    end
    tick();
    check("seq_idle", 64'(bus.commit_valid), 64'd0);
    check("seq_count0", 64'(bus.rob_count), 64'd0);

    // Fill to capacity from entry 3, wrapping.
    for (int i = 0; i < 8; i++) alloc(5'(8 + i), 1);
    check("full_count", 64'(bus.rob_count), 64'd8);
    alloc(5'd20, 0);
    check("full_hold_count", 64'(bus.rob_count), 64'd8);
    check("full_hold_tail", 64'(bus.alloc_entry), 64'd3);
    // Head completes; commit and refused alloc land on the same edge.
    cdb(3'd3, 32'h300, 1);
    alloc(5'd21, 0);
    check("full_commit", 64'(bus.commit_valid), 64'd1);
    check("full_commit_e", 64'(bus.commit_entry), 64'd3);
    check("after_commit_cnt", 64'(bus.rob_count), 64'd7);
    check("after_commit_rdy", 64'(bus.alloc_ready), 64'd1);
    alloc(5'd22, 1);
    check("refill_count", 64'(bus.rob_count), 64'd8);

    // CDB bypass on a pending entry, then storage, then a duplicate write.
    bus.q1_entry  = 3'd4;
    bus.cdb_write = 1'b1; bus.cdb_entry = 3'd4; bus.cdb_value = 32'hDEAD;
    mdl_val[4] = 32'hDEAD;
    #1;
    check("bypass_rdy", 64'(bus.q1_ready), 64'd1);
    check("bypass_val", 64'(bus.q1_value), 64'hDEAD);
    tick();
    bus.cdb_write = 1'b0;
    #1;
    check("stored_rdy", 64'(bus.q1_ready), 64'd1);
    check("stored_val", 64'(bus.q1_value), 64'hDEAD);
    bus.cdb_write = 1'b1; bus.cdb_value = 32'hBEEF;
    #1;
    check("dup_val", 64'(bus.q1_value), 64'hDEAD);
    tick();
    bus.cdb_write = 1'b0;
    check("dup_commit_val", 64'(bus.commit_value), 64'hDEAD);

    // Lookup table: head 5 pending, 6 and 0 done, 4 free.
    cdb(3'd6, 32'h66, 1);
    cdb(3'd0, 32'h100, 1);
    qv[0] = '{3'd6, 3'd0, 1'b0, 3'd0, 32'h0,   1'b1, 32'h66, 1'b1, 32'h100};
    qv[1] = '{3'd5, 3'd7, 1'b0, 3'd0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0};
    qv[2] = '{3'd5, 3'd7, 1'b1, 3'd5, 32'h55,  1'b1, 32'h55, 1'b0, 32'h0};
    qv[3] = '{3'd7, 3'd5, 1'b1, 3'd7, 32'h77,  1'b1, 32'h77, 1'b0, 32'h0};
    qv[4] = '{3'd6, 3'd4, 1'b1, 3'd6, 32'hBAD, 1'b1, 32'h66, 1'b0, 32'h0};
    qv[5] = '{3'd4, 3'd4, 1'b1, 3'd4, 32'h44,  1'b0, 32'h0,  1'b0, 32'h0};
    qv[6] = '{3'd1, 3'd0, 1'b1, 3'd1, 32'h11,  1'b1, 32'h11, 1'b1, 32'h100};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      bus.q1_entry = qv[i].q1; bus.q2_entry = qv[i].q2;
      bus.cdb_write = qv[i].cw; bus.cdb_entry = qv[i].ce; bus.cdb_value = qv[i].cv;
      #1;
      check($sformatf("qv%0d_r1", i), 64'(bus.q1_ready), 64'(qv[i].r1));
      check($sformatf("qv%0d_v1", i), 64'(bus.q1_value), 64'(qv[i].v1));
      check($sformatf("qv%0d_r2", i), 64'(bus.q2_ready), 64'(qv[i].r2));
      check($sformatf("qv%0d_v2", i), 64'(bus.q2_value), 64'(qv[i].v2));
      #1;
      bus.cdb_write = 1'b0;
    end
    tick();

    // Write to a free entry is dropped.
    cdb(3'd4, 32'h666, 0);
    check("nonbusy_count", 64'(bus.rob_count), 64'd7);
    cdb(3'd5, 32'h505, 1);
    cdb(3'd7, 32'h707, 1);
    cdb(3'd1, 32'h101, 1);
    cdb(3'd2, 32'h202, 1);
    cdb(3'd3, 32'h303, 1);
    drain(40);
    tick();
    check("drained_count", 64'(bus.rob_count), 64'd0);
    alloc(5'd9, 1);
    bus.q1_entry = 3'd4;
    #1;
    check("realloc_rdy", 64'(bus.q1_ready), 64'd0);
    check("realloc_val", 64'(bus.q1_value), 64'd0);

    // Reset with three entries live.
    alloc(5'd10, 1); alloc(5'd11, 1);
    cdb(3'd5, 32'h55, 1);
    bus.q1_entry = 3'd5;
    #1;
    check("pre_rst_q1", 64'(bus.q1_ready), 64'd1);
    rst = 1'b0;
    #1;
    check("rst_count", 64'(bus.rob_count), 64'd0);
    check("rst_ready", 64'(bus.alloc_ready), 64'd1);
    check("rst_entry", 64'(bus.alloc_entry), 64'd0);
    check("rst_cvalid", 64'(bus.commit_valid), 64'd0);
    check("rst_centry", 64'(bus.commit_entry), 64'd0);
    check("rst_creg", 64'(bus.commit_reg), 64'd0);
    check("rst_cvalue", 64'(bus.commit_value), 64'd0);
    check("rst_q1", 64'(bus.q1_ready), 64'd0);
    sb.delete();
    mdl_tail = '0;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_cvalid", 64'(bus.commit_valid), 64'd0);
      check("post_rst_count", 64'(bus.rob_count), 64'd0);
    end
    alloc(5'd3, 1);
    cdb(3'd0, 32'h77, 1);
    drain(10);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rob_commit_buffer.md
Name: rob_commit_buffer

Overview:
- Reorder buffer sitting directly downstream of the CDB.
- Decode allocates entries in program order; the CDB marks entries complete using its rob_write/rob_out_entry/rob_out_value outputs.
- The block retires completed results to the register file strictly in order, one per cycle.
- It also answers operand lookups from issue, so a locked register's value can be read before it commits.

Parameters:
- DATA_WIDTH, 32, result/value width (matches Data_Width).
- ENTRY_WIDTH, 3, entry index width (matches ROB_Entry_Width); DEPTH = 2**ENTRY_WIDTH = 8.
- REG_WIDTH, 5, architectural register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (entire block resets while rst==0).
- alloc_valid  in  1  decode requests one entry this cycle.
- alloc_dest_reg  in  REG_WIDTH  destination register of allocated instruction.
- alloc_ready  out  1  combinational; 1 when count != DEPTH.
- alloc_entry  out  ENTRY_WIDTH  combinational; current tail index (the entry granted on alloc).
- cdb_write  in  1  CDB result valid (from CDB rob_write).
- cdb_entry  in  ENTRY_WIDTH  entry being completed.
- cdb_value  in  DATA_WIDTH  result value.
- q1_entry, q2_entry  in  ENTRY_WIDTH  operand lookup indices.
- q1_ready, q2_ready  out  1  combinational; value available.
- q1_value, q2_value  out  DATA_WIDTH  combinational; value (0 when not ready).
- commit_valid  out  1  registered; one retire this cycle.
- commit_entry  out  ENTRY_WIDTH  registered; retired entry index (regfile clears lock only if lock still equals it).
- commit_reg  out  REG_WIDTH  registered; destination register.
- commit_value  out  DATA_WIDTH  registered; retired value.
- rob_count  out  ENTRY_WIDTH+1  registered; occupied entries, 0..DEPTH.

Behaviour:
- Storage: per entry busy, done, dest, value. Pointers head, tail (ENTRY_WIDTH, natural wrap DEPTH-1 -> 0); count (ENTRY_WIDTH+1).
- Reset (rst==0, async):
  - head=tail=count=0; all busy/done=0.
  - commit_valid=0, commit_entry=0, commit_reg=0, commit_value=0, rob_count=0.
  - Stored dest/value need not reset.
  - Reset asserted mid-operation discards all in-flight entries; no commit is emitted after release until new allocations complete.
- Allocate (alloc_valid && alloc_ready), at clk edge:
  - entry[tail].busy=1, done=0, dest=alloc_dest_reg; tail+1.
  - alloc_valid while full is ignored: no state change, tail unchanged.
- alloc_ready depends only on registered count. A commit in the same cycle does not free a slot early, so alloc_ready==0 whenever count==DEPTH.
- CDB write, at clk edge:
  - If entry[cdb_entry].busy && !done: value=cdb_value, done=1.
  - A write to a non-busy or already-done entry is ignored (no overwrite).
- Commit, evaluated on registered state each cycle:
  - If entry[head].busy && done: commit_valid<=1, commit_entry<=head, commit_reg<=dest, commit_value<=value; busy<=0; head+1.
  - Otherwise commit_valid<=0; other commit outputs hold their last values.
  - Latency: a CDB write at edge N makes done visible at N; commit_valid is high after edge N+1. This holds for a CDB write to the head entry as well (no same-cycle commit bypass).
  - Dest reg 0 is committed normally; the regfile discards it.
- Count: +1 on alloc only, -1 on commit only, unchanged when both or neither occur. rob_count mirrors count.
- Simultaneous alloc into slot X and CDB write to slot X cannot both take effect: the CDB write targets a non-busy entry and is ignored; allocation wins.
- Query (per port, combinational):
  - If cdb_write && cdb_entry==qN_entry && entry busy && !done: ready=1, value=cdb_value (CDB bypass).
  - Else if busy && done: ready=1, value=stored value.
  - Else ready=0, value=0.
- Throughput: at most one alloc, one CDB write and one commit per cycle.

Decomposition:
- Shared defines header additions: ROB_Depth, ROB_Entry_Width, Reg_Index_Width. Reuse Data_Width and Reg_No_Lock.
- Natural sub-module: rob_query_port, the combinational lookup plus CDB bypass, instantiated twice.
- Pointer/count logic and commit stay in the top module.

Test Plan:
- Reset then idle -> rob_count=0, alloc_ready=1, alloc_entry=0, commit_valid=0 for 10 cycles. Assert rst low mid-run with 3 entries live -> all outputs 0 immediately, no commits afterwards.
- Alloc r1,r2,r3 (entries 0,1,2); CDB writes entry2=0x33, then 1=0x22, then 0=0x11 -> commits in order 0/r1/0x11, 1/r2/0x22, 2/r3/0x33, one per cycle starting one cycle after the entry-0 write.
- Alloc 8 back-to-back -> alloc_ready=0, rob_count=8; a 9th alloc_valid is ignored. Complete entry0 -> commit, then alloc_ready=1 and the next alloc gets entry 0 (wrap).
- Full buffer, same cycle commit of head and alloc_valid -> alloc refused that cycle; alloc in the following cycle succeeds with rob_count=8 again.
- Entry 4 busy, not done; q1_entry=4 with cdb_write entry4=0xDEAD same cycle -> q1_ready=1, q1_value=0xDEAD combinationally. Next cycle, with no CDB write -> still 0xDEAD from storage. Duplicate CDB write entry4=0xBEEF -> ignored, value stays 0xDEAD.
- CDB write to a non-busy entry 6 -> no state change; a later alloc of entry 6 shows q ready=0.
